reset_seq: RTL and testbench

Reset sequencer directly downstream of the PLL clock generator. Consumes the PLL lock indication, a board reset button and internal reset requests. Produces one clean, synchronous, active-low system reset in the `clk_sys` domain. Latches the cause of the most recent reset so software can read it after restart.

---
 rtl/reset_pkg.sv | 18 +
 rtl/sync2.sv | 24 ++
 rtl/reset_seq.sv | 134 +++++++++++++
 tb/tb_reset_seq.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reset_pkg.sv
// Shared definitions for the system reset sequencer:
// FSM state encoding and reset-cause bit positions.
package reset_pkg;

  localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
  localparam logic [1:0] ST_HOLD      = 2'd1;
  localparam logic [1:0] ST_RUN       = 2'd2;

  localparam logic [1:0] CAUSE_LOCK = 2'd0;
  localparam logic [1:0] CAUSE_BTN  = 2'd1;
  localparam logic [1:0] CAUSE_SW   = 2'd2;
  localparam logic [1:0] CAUSE_WD   = 2'd3;

  function automatic logic [3:0] cause_oh(input logic [1:0] idx);
    cause_oh = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for slow asynchronous level inputs,
// with a parameterised synchronous reset value.
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/reset_seq.sv
// System reset sequencer: PLL lock, debounced button, sw/watchdog requests.
// Define RST_WDOG_EN to add the wd_rst input and watchdog cause bit.
module reset_seq
  import reset_pkg::*;
#(
  parameter int HOLD_CYC     = 16,
  parameter int DEBOUNCE_CYC = 250000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_ok,
  input  logic       btn_n,
  input  logic       sw_rst,
`ifdef RST_WDOG_EN
  input  logic       wd_rst,
`endif
  output logic       rst_out_n,
  output logic [3:0] rst_cause,
  output logic       busy
);

  localparam int HW = $clog2(HOLD_CYC);
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYC - 1);
  localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE_CYC);

  logic          lock;
  logic          btn_s;
  logic          btn_press;
  logic          wd_ev;
  logic [DW-1:0] deb_q;
  logic [HW-1:0] hold_q, hold_d;
  logic [1:0]    state_q, state_d;
  logic [3:0]    cause_q, cause_d;
  logic          rst_q;

`ifdef RST_WDOG_EN
  assign wd_ev = wd_rst;
`else
  assign wd_ev = 1'b0;
`endif

  sync2 #(.RST_VAL(1'b0)) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (clk_ok),
    .q     (lock)
  );

  sync2 #(.RST_VAL(1'b1)) u_btn_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_n),
    .q     (btn_s)
  );

  always_ff @(posedge clk) begin
    if (!rst_n)
      deb_q <= '0;
    else if (btn_s)
      deb_q <= '0;
    else if (deb_q != DEB_MAX)
      deb_q <= deb_q + 1'b1;
  end

  assign btn_press = (deb_q == DEB_MAX);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cause_d = cause_q;
    unique case (state_q)
      ST_WAIT_LOCK: begin
        if (lock) begin
          state_d = ST_HOLD;
          hold_d  = HOLD_LOAD;
        end
      end
      ST_HOLD: begin
        if (!lock) begin
          state_d = ST_WAIT_LOCK;
          cause_d = cause_oh(CAUSE_LOCK);
        end else if (btn_press) begin
          hold_d = HOLD_LOAD;
        end else if (hold_q == '0) begin
          state_d = ST_RUN;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      ST_RUN: begin
        // Event priority: lock, button, watchdog, software
        if (!lock) begin
          state_d = ST_WAIT_LOCK;
          cause_d = cause_oh(CAUSE_LOCK);
        end else if (btn_press) begin
          state_d = ST_HOLD;
          hold_d  = HOLD_LOAD;
          cause_d = cause_oh(CAUSE_BTN);
        end else if (wd_ev) begin
          state_d = ST_HOLD;
          hold_d  = HOLD_LOAD;
          cause_d = cause_oh(CAUSE_WD);
        end else if (sw_rst) begin
          state_d = ST_HOLD;
          hold_d  = HOLD_LOAD;
          cause_d = cause_oh(CAUSE_SW);
        end
      end
      default: begin
        state_d = ST_WAIT_LOCK;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_WAIT_LOCK;
      hold_q  <= '0;
      cause_q <= cause_oh(CAUSE_LOCK);
      rst_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cause_q <= cause_d;
      rst_q   <= (state_d == ST_RUN);
    end
  end

  assign rst_out_n = rst_q;
  assign rst_cause = cause_q;
  assign busy      = (state_q != ST_RUN);

endmodule

// File: tb/tb_reset_seq.sv
// Randomised + directed bench for reset_seq against a cycle model.
// Honours RST_WDOG_EN for the watchdog port.
module tb_reset_seq;

  localparam int HOLD = 16;
  localparam int DEB  = 8;
`ifdef RST_WDOG_EN
  localparam bit WDOG = 1'b1;
`else
  localparam bit WDOG = 1'b0;
`endif

  localparam logic [3:0] C_LOCK = 4'b0001;
  localparam logic [3:0] C_BTN  = 4'b0010;
  localparam logic [3:0] C_SW   = 4'b0100;
  localparam logic [3:0] C_WD   = 4'b1000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_ok = 1'b0;
  logic       btn_n = 1'b1;
  logic       sw_rst = 1'b0;
  logic       wd_rst = 1'b0;
  logic       rst_out_n;
  logic       busy;
  logic [3:0] rst_cause;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  reset_seq #(
    .HOLD_CYC     (HOLD),
    .DEBOUNCE_CYC (DEB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_ok    (clk_ok),
    .btn_n     (btn_n),
    .sw_rst    (sw_rst),
`ifdef RST_WDOG_EN
    .wd_rst    (wd_rst),
`endif
    .rst_out_n (rst_out_n),
    .rst_cause (rst_cause),
    .busy      (busy)
  );

  typedef enum {M_WAIT, M_HOLD, M_RUN} mode_e;

  mode_e      m_mode;
  int         m_left;
  int         m_low;
  bit         m_lock[2];
  bit         m_btn[2];
  logic [3:0] m_cause;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h want %0h", tag, $time, got, exp);
    end
  endtask

  task automatic m_reset();
    m_mode  = M_WAIT;
    m_left  = 0;
    m_low   = 0;
    m_lock  = '{1'b0, 1'b0};
    m_btn   = '{1'b1, 1'b1};
    m_cause = C_LOCK;
  endtask

  task automatic m_enter_hold(input logic [3:0] c);
    m_mode  = M_HOLD;
    m_left  = HOLD;
    m_cause = c;
  endtask

  // One clock edge of the reference behaviour
  task automatic m_step();
    bit lk;
    bit pr;
    if (!rst_n) begin
      m_reset();
      return;
    end
    lk = m_lock[0];
    pr = (m_low >= DEB);
    case (m_mode)
      M_WAIT: if (lk) begin
        m_mode = M_HOLD;
        m_left = HOLD;
      end
      M_HOLD: begin
        if (!lk) begin
          m_mode  = M_WAIT;
          m_cause = C_LOCK;
        end else if (pr) begin
          m_left = HOLD;
        end else begin
          m_left--;
          if (m_left == 0) m_mode = M_RUN;
        end
      end
      M_RUN: begin
        if (!lk) begin
          m_mode  = M_WAIT;
          m_cause = C_LOCK;
        end else if (pr) m_enter_hold(C_BTN);
        else if (WDOG && wd_rst) m_enter_hold(C_WD);
        else if (sw_rst) m_enter_hold(C_SW);
      end
      default: m_mode = M_WAIT;
    endcase
    if (m_btn[0]) m_low = 0;
    else if (m_low < DEB) m_low++;
    m_lock = '{m_lock[1], clk_ok};
    m_btn  = '{m_btn[1], btn_n};
  endtask

  task automatic tick();
    @(posedge clk);
    m_step();
    #1;
    chk("rst_out_n", 32'(rst_out_n), 32'(m_mode == M_RUN));
    chk("busy", 32'(busy), 32'(m_mode != M_RUN));
    chk("rst_cause", 32'(rst_cause), 32'(m_cause));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_lvl(input logic lvl, input int maxc, output int n);
    n = 0;
    while (rst_out_n !== lvl && n < maxc) begin
      tick();
      n++;
    end
  endtask

  task automatic pulse_sw();
    sw_rst = 1'b1;
    tick();
    sw_rst = 1'b0;
  endtask

  int n;
  int btn_left;
  int lock_left;
  int rst_left;

  initial begin
    m_reset();

    ticks(4);
    chk("por_rst_out_n", 32'(rst_out_n), 32'd0);
    chk("por_busy", 32'(busy), 32'd1);
    chk("por_cause", 32'(rst_cause), 32'(C_LOCK));

    rst_n = 1'b1;
    ticks(2);
    clk_ok = 1'b1;
    wait_lvl(1'b1, 100, n);
    chk("lock_release_lat", 32'(n), 32'(HOLD + 3));

    ticks(3);
    pulse_sw();
    chk("sw_low", 32'(rst_out_n), 32'd0);
    chk("sw_cause", 32'(rst_cause), 32'(C_SW));
    wait_lvl(1'b1, 100, n);
    chk("sw_hold_lat", 32'(n), 32'(HOLD));

    for (int k = 0; k < 3; k++) begin
      btn_n = 1'b0;
      ticks(5);
      btn_n = 1'b1;
      ticks(3);
    end
    chk("bounce_ignored", 32'(rst_out_n), 32'd1);

    btn_n = 1'b0;
    wait_lvl(1'b0, 100, n);
    chk("btn_fall_lat", 32'(n), 32'(DEB + 3));
    ticks(20 - n);
    btn_n = 1'b1;
    wait_lvl(1'b1, 100, n);
    chk("btn_release_lat", 32'(n), 32'(HOLD + 3));
    chk("btn_cause", 32'(rst_cause), 32'(C_BTN));

    pulse_sw();
    ticks(2);
    clk_ok = 1'b0;
    ticks(3);
    chk("hold_lockloss_cause", 32'(rst_cause), 32'(C_LOCK));
    chk("hold_lockloss_busy", 32'(busy), 32'd1);
    clk_ok = 1'b1;
    wait_lvl(1'b1, 100, n);
    chk("relock_lat", 32'(n), 32'(HOLD + 3));

    ticks(2);
    clk_ok = 1'b0;
    wait_lvl(1'b0, 10, n);
    chk("run_lockloss_lat", 32'(n), 32'd3);
    chk("run_lockloss_cause", 32'(rst_cause), 32'(C_LOCK));
    clk_ok = 1'b1;
    wait_lvl(1'b1, 100, n);

    sw_rst = 1'b1;
    wd_rst = 1'b1;
    tick();
    sw_rst = 1'b0;
    wd_rst = 1'b0;
    chk("simul_cause", 32'(rst_cause), 32'(WDOG ? C_WD : C_SW));
    wait_lvl(1'b1, 100, n);

    pulse_sw();
    ticks(4);
    rst_n = 1'b0;
    tick();
    chk("midhold_rst_out_n", 32'(rst_out_n), 32'd0);
    chk("midhold_busy", 32'(busy), 32'd1);
    chk("midhold_cause", 32'(rst_cause), 32'(C_LOCK));
    rst_n = 1'b1;
    wait_lvl(1'b1, 100, n);
    chk("midhold_release_lat", 32'(n), 32'(HOLD + 3));

    btn_left = 0;
    lock_left = 0;
    rst_left = 0;
    for (int c = 0; c < 3000; c++) begin
      sw_rst = ($urandom_range(0, 29) == 0);
      wd_rst = ($urandom_range(0, 49) == 0);
      if (btn_left > 0) begin
        btn_left--;
      end else if ($urandom_range(0, 59) == 0) begin
        btn_left = $urandom_range(1, 20);
      end
      btn_n = (btn_left == 0);
      if (lock_left > 0) begin
        lock_left--;
      end else if ($urandom_range(0, 299) == 0) begin
        lock_left = $urandom_range(1, 30);
      end
      clk_ok = (lock_left == 0);
      if (rst_left > 0) begin
        rst_left--;
      end else if ($urandom_range(0, 499) == 0) begin
        rst_left = $urandom_range(1, 3);
      end
      rst_n = (rst_left == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
